// File: rtl/periph_bus_pkg.sv
// periph_bus_pkg
// Shared definitions for the peripheral bus fabric:
//   - state_t       : fabric FSM state encoding
//   - IDX_W         : width of the decoded slave index (up to 15 slaves)
//   - BSIZE_*       : byte-size codes carried on io_byte_size / slv_byte_size
//   - DEF_SLV_BASE/END : default address windows for 4 slaves of 32 bits
//   - lowest_set_plus1 : priority encoder used for the interrupt code
package periph_bus_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ACCESS  = 2'd1,
    ST_RESP    = 2'd2,
    ST_RELEASE = 2'd3
  } state_t;

  localparam int IDX_W = 4;

  localparam logic [1:0] BSIZE_BYTE = 2'b00;
  localparam logic [1:0] BSIZE_HALF = 2'b01;
  localparam logic [1:0] BSIZE_WORD = 2'b10;

  // Slice i belongs to slave i; windows are inclusive.
  localparam logic [127:0] DEF_SLV_BASE = {32'h3000_0000, 32'h2000_0000,
                                           32'h1000_0000, 32'h0000_0000};
  localparam logic [127:0] DEF_SLV_END  = {32'h3FFF_FFFF, 32'h2FFF_FFFF,
                                           32'h1FFF_FFFF, 32'h0FFF_FFFF};

  // Returns index+1 of the lowest set bit, 0 when no bit is set.
  function automatic int unsigned lowest_set_plus1(input logic [14:0] v);
    int unsigned r;
    r = 0;
    for (int i = 14; i >= 0; i--) begin
      if (v[i]) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/periph_bus_fabric_if.sv
// periph_bus_fabric_if
// Master-side request/response bus of the peripheral fabric.
//   master modport : requester (CPU side) drives the request, sees the response
//   slave modport  : fabric side, sees the request, drives the response
// Signals: io_addr, io_wdata, io_byte_size, io_read, io_write, read_ready
//          (request); io_rdata, io_ready, io_err (response).
interface periph_bus_fabric_if #(
  parameter int XLEN = 32
);
  logic [XLEN-1:0] io_addr;
  logic [XLEN-1:0] io_wdata;
  logic [1:0]      io_byte_size;
  logic            io_read;
  logic            io_write;
  logic            read_ready;
  logic [XLEN-1:0] io_rdata;
  logic            io_ready;
  logic            io_err;

  modport master (
    output io_addr, io_wdata, io_byte_size, io_read, io_write, read_ready,
    input  io_rdata, io_ready, io_err
  );

  modport slave (
    input  io_addr, io_wdata, io_byte_size, io_read, io_write, read_ready,
    output io_rdata, io_ready, io_err
  );
endinterface

// File: rtl/periph_addr_decode.sv
// periph_addr_decode
// Combinational address decoder.
//   addr : address to decode
//   hit  : one bit per slave whose inclusive window contains addr
//   idx  : lowest hitting slave index (overlaps resolve to the lowest index)
//   miss : no window contains addr
module periph_addr_decode
  import periph_bus_pkg::*;
#(
  parameter int XLEN       = 32,
  parameter int NUM_SLAVES = 4,
  parameter logic [NUM_SLAVES*XLEN-1:0] SLV_BASE = DEF_SLV_BASE,
  parameter logic [NUM_SLAVES*XLEN-1:0] SLV_END  = DEF_SLV_END
) (
  input  logic [XLEN-1:0]       addr,
  output logic [NUM_SLAVES-1:0] hit,
  output logic [IDX_W-1:0]      idx,
  output logic                  miss
);

  always_comb begin
    hit  = '0;
    idx  = '0;
    miss = 1'b1;
    for (int i = 0; i < NUM_SLAVES; i++) begin
      hit[i] = (addr >= SLV_BASE[i*XLEN +: XLEN]) && (addr <= SLV_END[i*XLEN +: XLEN]);
    end
    // Descending scan so the lowest hitting index is the one left standing.
    for (int i = NUM_SLAVES - 1; i >= 0; i--) begin
      if (hit[i]) begin
        idx  = IDX_W'(i);
        miss = 1'b0;
      end
    end
  end

endmodule

// File: rtl/periph_bus_fabric.sv
// periph_bus_fabric
// Single-master to NUM_SLAVES peripheral bus fabric with interrupt encoding.
// Ports:
//   pclk, rst_n         : clock, asynchronous active-low reset
//   bus (slave modport) : master request (io_addr/io_wdata/io_byte_size/
//                         io_read/io_write/read_ready) and response
//                         (io_rdata/io_ready/io_err)
//   slv_addr/slv_wdata/slv_byte_size : latched request to the slaves
//   slv_read/slv_write  : per-slave strobes, only the selected slave in ACCESS
//   slv_rdata/slv_ready : per-slave read data and completion
//   slv_int             : per-slave interrupt requests
//   peripheral_int_code : registered index+1 of lowest pending interrupt
// Build option: define PBUS_TIMEOUT_EN to abort an ACCESS with io_err after
// TIMEOUT_CYCLES cycles without slv_ready; otherwise ACCESS waits forever.
module periph_bus_fabric
  import periph_bus_pkg::*;
#(
  parameter int XLEN           = 32,
  parameter int NUM_SLAVES     = 4,
  parameter int INT_CODE_WIDTH = 4,
  parameter int TIMEOUT_CYCLES = 16,
  parameter logic [NUM_SLAVES*XLEN-1:0] SLV_BASE = DEF_SLV_BASE,
  parameter logic [NUM_SLAVES*XLEN-1:0] SLV_END  = DEF_SLV_END
) (
  input  logic                         pclk,
  input  logic                         rst_n,
  periph_bus_fabric_if.slave           bus,
  output logic [XLEN-1:0]              slv_addr,
  output logic [XLEN-1:0]              slv_wdata,
  output logic [1:0]                   slv_byte_size,
  output logic [NUM_SLAVES-1:0]        slv_read,
  output logic [NUM_SLAVES-1:0]        slv_write,
  input  logic [NUM_SLAVES*XLEN-1:0]   slv_rdata,
  input  logic [NUM_SLAVES-1:0]        slv_ready,
  input  logic [NUM_SLAVES-1:0]        slv_int,
  output logic [INT_CODE_WIDTH-1:0]    peripheral_int_code
);

  if (NUM_SLAVES < 1 || NUM_SLAVES > 15 || TIMEOUT_CYCLES < 1) begin : g_bad_cfg
    $error("periph_bus_fabric: NUM_SLAVES must be 1..15 and TIMEOUT_CYCLES >= 1");
  end

  state_t                    state, state_nxt;
  logic [NUM_SLAVES-1:0]     dec_hit;
  logic [IDX_W-1:0]          dec_idx;
  logic                      dec_miss;
  logic [NUM_SLAVES-1:0]     sel_nxt;
  logic                      req_any, req_both;

  logic [NUM_SLAVES-1:0]     sel_q;
  logic [IDX_W-1:0]          sel_idx_q;
  logic                      wr_q;
  logic                      err_q;
  logic [XLEN-1:0]           rdata_q;
  logic [XLEN-1:0]           addr_q;
  logic [XLEN-1:0]           wdata_q;
  logic [1:0]                bsize_q;
  logic [INT_CODE_WIDTH-1:0] int_code_q;
  logic [14:0]               int_vec;

  logic                      sel_ready;
  logic [XLEN-1:0]           sel_rdata;
  logic                      timeout_hit;

  assign req_any  = bus.io_read | bus.io_write;
  assign req_both = bus.io_read & bus.io_write;

  periph_addr_decode #(
    .XLEN       (XLEN),
    .NUM_SLAVES (NUM_SLAVES),
    .SLV_BASE   (SLV_BASE),
    .SLV_END    (SLV_END)
  ) u_decode (
    .addr (bus.io_addr),
    .hit  (dec_hit),
    .idx  (dec_idx),
    .miss (dec_miss)
  );

  // Isolate the lowest hit bit so overlapping windows strobe one slave only.
  assign sel_nxt = dec_hit & (~dec_hit + NUM_SLAVES'(1));

  // Only the selected slave's ready/data are ever looked at.
  assign sel_ready = |(slv_ready & sel_q);

  always_comb begin
    sel_rdata = '0;
    for (int i = 0; i < NUM_SLAVES; i++) begin
      if (sel_idx_q == IDX_W'(i)) sel_rdata = slv_rdata[i*XLEN +: XLEN];
    end
  end

`ifdef PBUS_TIMEOUT_EN
  localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [TMO_W-1:0] tmo_cnt;

  // Counts completed ACCESS cycles of the current transfer.
  always_ff @(posedge pclk or negedge rst_n) begin
    if (!rst_n) begin
      tmo_cnt <= '0;
    end else if (state == ST_ACCESS && state_nxt == ST_ACCESS) begin
      tmo_cnt <= tmo_cnt + 1'b1;
    end else begin
      tmo_cnt <= '0;
    end
  end

  assign timeout_hit = (state == ST_ACCESS) && !sel_ready &&
                       (tmo_cnt == TMO_W'(TIMEOUT_CYCLES - 1));
`else
  assign timeout_hit = 1'b0;
`endif

  // FSM next state and outputs
  always_comb begin
    state_nxt    = state;
    slv_read     = '0;
    slv_write    = '0;
    bus.io_ready = 1'b0;
    bus.io_err   = 1'b0;
    case (state)
      ST_IDLE: begin
        if (req_any) state_nxt = (req_both || dec_miss) ? ST_RESP : ST_ACCESS;
      end
      ST_ACCESS: begin
        if (wr_q) slv_write = sel_q;
        else      slv_read  = sel_q;
        if (sel_ready || timeout_hit) state_nxt = ST_RESP;
      end
      ST_RESP: begin
        bus.io_ready = 1'b1;
        bus.io_err   = err_q;
        // Reads wait for the master to accept the data; writes/errors do not.
        if (wr_q || err_q || bus.read_ready) state_nxt = ST_RELEASE;
      end
      ST_RELEASE: begin
        if (!bus.io_read && !bus.io_write) state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Control registers
  always_ff @(posedge pclk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ST_IDLE;
      sel_q      <= '0;
      sel_idx_q  <= '0;
      wr_q       <= 1'b0;
      err_q      <= 1'b0;
      rdata_q    <= '0;
      int_code_q <= '0;
    end else begin
      state      <= state_nxt;
      int_code_q <= INT_CODE_WIDTH'(lowest_set_plus1(int_vec));
      case (state)
        ST_IDLE: begin
          if (req_any) begin
            wr_q <= bus.io_write & ~bus.io_read;
            if (req_both || dec_miss) begin
              err_q   <= 1'b1;
              rdata_q <= '0;
              sel_q   <= '0;
            end else begin
              err_q     <= 1'b0;
              sel_q     <= sel_nxt;
              sel_idx_q <= dec_idx;
            end
          end
        end
        ST_ACCESS: begin
          if (sel_ready) begin
            err_q <= 1'b0;
            if (!wr_q) rdata_q <= sel_rdata;
          end else if (timeout_hit) begin
            err_q   <= 1'b1;
            rdata_q <= '0;
          end
        end
        default: ;
      endcase
    end
  end

  // Request data latch
  always_ff @(posedge pclk) begin
    if (state == ST_IDLE && req_any) begin
      addr_q  <= bus.io_addr;
      wdata_q <= bus.io_wdata;
      bsize_q <= bus.io_byte_size;
    end
  end

  assign int_vec             = 15'(slv_int);
  assign peripheral_int_code = int_code_q;
  assign bus.io_rdata        = rdata_q;
  assign slv_addr            = addr_q;
  assign slv_wdata           = wdata_q;
  assign slv_byte_size       = bsize_q;

endmodule

// File: tb/tb_periph_bus_fabric.sv
// tb_periph_bus_fabric
// Directed bench for periph_bus_fabric. Slave windows: 0 = 0x0000_0000..0x0000_FFFF,
// 1 = 0x1000_0000..0x1FFF_FFFF, 2 = 0x0000_8000..0x0001_FFFF (overlaps slave 0),
// 3 = 0x3000_0000..0x3FFF_FFFF. 0xFFFF_0000 is unmapped.
// Timeout scenario follows PBUS_TIMEOUT_EN.
module tb_periph_bus_fabric;
  import periph_bus_pkg::*;

  localparam logic [127:0] BASE = {32'h3000_0000, 32'h0000_8000, 32'h1000_0000, 32'h0000_0000};
  localparam logic [127:0] ENDA = {32'h3FFF_FFFF, 32'h0001_FFFF, 32'h1FFF_FFFF, 32'h0000_FFFF};

  logic         pclk;
  logic         rst_n;
  logic [31:0]  slv_addr, slv_wdata;
  logic [1:0]   slv_byte_size;
  logic [3:0]   slv_read, slv_write;
  logic [127:0] slv_rdata;
  logic [3:0]   slv_ready, slv_int;
  logic [3:0]   peripheral_int_code;

  int n_tests = 0;
  int n_fail  = 0;

  periph_bus_fabric_if #(.XLEN(32)) bus ();

  periph_bus_fabric #(
    .XLEN(32), .NUM_SLAVES(4), .INT_CODE_WIDTH(4), .TIMEOUT_CYCLES(16),
    .SLV_BASE(BASE), .SLV_END(ENDA)
  ) dut (
    .pclk(pclk), .rst_n(rst_n), .bus(bus),
    .slv_addr(slv_addr), .slv_wdata(slv_wdata), .slv_byte_size(slv_byte_size),
    .slv_read(slv_read), .slv_write(slv_write), .slv_rdata(slv_rdata),
    .slv_ready(slv_ready), .slv_int(slv_int),
    .peripheral_int_code(peripheral_int_code)
  );

  initial pclk = 1'b0;
  always #5 pclk = ~pclk;

  task automatic tick();
    @(posedge pclk);
    #1;
  endtask

  task automatic test_reset();
    slv_int = 4'b1111;
    tick(); tick();
    n_tests++; if (bus.io_ready !== 1'b0) begin n_fail++; $display("FAIL rst_ready: got %b want 0", bus.io_ready); end
    n_tests++; if (bus.io_err !== 1'b0) begin n_fail++; $display("FAIL rst_err: got %b want 0", bus.io_err); end
    n_tests++; if (bus.io_rdata !== 32'h0) begin n_fail++; $display("FAIL rst_rdata: got %h want 0", bus.io_rdata); end
    n_tests++; if ({slv_read, slv_write} !== 8'h00) begin n_fail++; $display("FAIL rst_strobes: got %b/%b want 0/0", slv_read, slv_write); end
    n_tests++; if (peripheral_int_code !== 4'd0) begin n_fail++; $display("FAIL rst_int: got %0d want 0", peripheral_int_code); end
    slv_int = 4'b0000;
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_read_hit();
    slv_rdata[63:32] = 32'hDEAD_BEEF;
    slv_ready = 4'b0010;
    bus.io_addr = 32'h1000_0004; bus.io_byte_size = BSIZE_WORD; bus.io_read = 1'b1;
    tick();
    n_tests++; if (slv_read !== 4'b0010) begin n_fail++; $display("FAIL rd_strobe: got %b want 0010", slv_read); end
    n_tests++; if (slv_addr !== 32'h1000_0004) begin n_fail++; $display("FAIL rd_addr: got %h want 10000004", slv_addr); end
    n_tests++; if (bus.io_ready !== 1'b0) begin n_fail++; $display("FAIL rd_early_ready: got %b want 0", bus.io_ready); end
    tick();
    n_tests++; if (bus.io_ready !== 1'b1) begin n_fail++; $display("FAIL rd_ready: got %b want 1", bus.io_ready); end
    n_tests++; if (bus.io_rdata !== 32'hDEAD_BEEF) begin n_fail++; $display("FAIL rd_data: got %h want deadbeef", bus.io_rdata); end
    n_tests++; if (bus.io_err !== 1'b0) begin n_fail++; $display("FAIL rd_err: got %b want 0", bus.io_err); end
    n_tests++; if (slv_read !== 4'b0000) begin n_fail++; $display("FAIL rd_strobe_resp: got %b want 0000", slv_read); end
    slv_rdata[63:32] = 32'h0;
    tick();
    n_tests++; if (bus.io_ready !== 1'b1) begin n_fail++; $display("FAIL rd_hold_resp: got %b want 1", bus.io_ready); end
    bus.read_ready = 1'b1;
    tick();
    n_tests++; if (bus.io_ready !== 1'b0) begin n_fail++; $display("FAIL rd_release_ready: got %b want 0", bus.io_ready); end
    tick();
    n_tests++; if ({bus.io_ready, slv_read} !== 5'b0) begin n_fail++; $display("FAIL rd_no_reissue: got %b/%b want 0/0000", bus.io_ready, slv_read); end
    bus.io_read = 1'b0; bus.read_ready = 1'b0;
    tick();
    n_tests++; if (bus.io_rdata !== 32'hDEAD_BEEF) begin n_fail++; $display("FAIL rd_data_hold: got %h want deadbeef", bus.io_rdata); end
    slv_ready = 4'b0000;
  endtask

  task automatic test_unselected_ready();
    slv_rdata[127:96] = 32'h3333_0003; slv_rdata[31:0] = 32'hBAD0_0000;
    slv_ready = 4'b0001;
    bus.io_addr = 32'h3000_0010; bus.io_read = 1'b1;
    tick(); tick(); tick();
    n_tests++; if (slv_read !== 4'b1000) begin n_fail++; $display("FAIL unsel_strobe: got %b want 1000", slv_read); end
    n_tests++; if (bus.io_ready !== 1'b0) begin n_fail++; $display("FAIL unsel_ready: got %b want 0", bus.io_ready); end
    slv_ready = 4'b1000;
    tick();
    n_tests++; if (bus.io_rdata !== 32'h3333_0003) begin n_fail++; $display("FAIL unsel_data: got %h want 33330003", bus.io_rdata); end
    bus.read_ready = 1'b1; bus.io_read = 1'b0;
    tick(); tick();
    bus.read_ready = 1'b0; slv_ready = 4'b0000;
  endtask

  task automatic test_both_high();
    slv_ready = 4'b0010;
    bus.io_addr = 32'h1000_0000; bus.io_read = 1'b1; bus.io_write = 1'b1;
    tick();
    n_tests++; if ({slv_read, slv_write} !== 8'h00) begin n_fail++; $display("FAIL both_strobes: got %b/%b want 0/0", slv_read, slv_write); end
    n_tests++; if ({bus.io_ready, bus.io_err} !== 2'b11) begin n_fail++; $display("FAIL both_resp: got rdy %b err %b want 1 1", bus.io_ready, bus.io_err); end
    n_tests++; if (bus.io_rdata !== 32'h0) begin n_fail++; $display("FAIL both_rdata: got %h want 0", bus.io_rdata); end
    tick();
    bus.io_read = 1'b0; bus.io_write = 1'b0; slv_ready = 4'b0000;
    tick();
  endtask

  task automatic test_write_miss();
    bus.io_addr = 32'hFFFF_0000; bus.io_wdata = 32'h0000_1234; bus.io_write = 1'b1;
    tick();
    n_tests++; if ({slv_read, slv_write} !== 8'h00) begin n_fail++; $display("FAIL wmiss_strobes: got %b/%b want 0/0", slv_read, slv_write); end
    n_tests++; if ({bus.io_ready, bus.io_err} !== 2'b11) begin n_fail++; $display("FAIL wmiss_resp: got rdy %b err %b want 1 1", bus.io_ready, bus.io_err); end
    n_tests++; if (bus.io_rdata !== 32'h0) begin n_fail++; $display("FAIL wmiss_rdata: got %h want 0", bus.io_rdata); end
    tick();
    n_tests++; if ({bus.io_ready, bus.io_err} !== 2'b00) begin n_fail++; $display("FAIL wmiss_one_cycle: got rdy %b err %b want 0 0", bus.io_ready, bus.io_err); end
    tick();
    n_tests++; if ({bus.io_ready, slv_write} !== 5'b0) begin n_fail++; $display("FAIL wmiss_release: got %b/%b want 0/0000", bus.io_ready, slv_write); end
    bus.io_write = 1'b0;
    tick();
  endtask

  task automatic test_write_hit();
    slv_ready = 4'b0001;
    bus.io_addr = 32'h0000_0100; bus.io_wdata = 32'hA5A5_5A5A; bus.io_byte_size = BSIZE_BYTE;
    bus.io_write = 1'b1;
    tick();
    n_tests++; if ({slv_write, slv_read} !== 8'b0001_0000) begin n_fail++; $display("FAIL wr_strobe: got %b/%b want 0001/0000", slv_write, slv_read); end
    n_tests++; if (slv_wdata !== 32'hA5A5_5A5A) begin n_fail++; $display("FAIL wr_wdata: got %h want a5a55a5a", slv_wdata); end
    n_tests++; if (slv_byte_size !== 2'b00) begin n_fail++; $display("FAIL wr_bsize: got %b want 00", slv_byte_size); end
    tick();
    n_tests++; if ({bus.io_ready, bus.io_err} !== 2'b10) begin n_fail++; $display("FAIL wr_resp: got rdy %b err %b want 1 0", bus.io_ready, bus.io_err); end
    n_tests++; if (bus.io_rdata !== 32'h0) begin n_fail++; $display("FAIL wr_rdata_hold: got %h want 0", bus.io_rdata); end
    tick();
    n_tests++; if (bus.io_ready !== 1'b0) begin n_fail++; $display("FAIL wr_one_cycle: got %b want 0", bus.io_ready); end
    bus.io_write = 1'b0; slv_ready = 4'b0000;
    tick();
  endtask

  task automatic test_overlap();
    slv_rdata[31:0] = 32'h0000_0A0A; slv_rdata[95:64] = 32'h0000_2C2C;
    slv_ready = 4'b0101;
    bus.io_addr = 32'h0000_9000; bus.io_read = 1'b1;
    tick();
    n_tests++; if (slv_read !== 4'b0001) begin n_fail++; $display("FAIL ovl_strobe: got %b want 0001", slv_read); end
    tick();
    n_tests++; if (bus.io_rdata !== 32'h0000_0A0A) begin n_fail++; $display("FAIL ovl_data: got %h want 00000a0a", bus.io_rdata); end
    bus.read_ready = 1'b1; bus.io_read = 1'b0;
    tick(); tick();
    bus.read_ready = 1'b0;
    bus.io_addr = 32'h0001_0000; bus.io_read = 1'b1;
    tick();
    n_tests++; if (slv_read !== 4'b0100) begin n_fail++; $display("FAIL ovl_s2_strobe: got %b want 0100", slv_read); end
    tick();
    n_tests++; if (bus.io_rdata !== 32'h0000_2C2C) begin n_fail++; $display("FAIL ovl_s2_data: got %h want 00002c2c", bus.io_rdata); end
    bus.read_ready = 1'b1; bus.io_read = 1'b0;
    tick(); tick();
    bus.read_ready = 1'b0; slv_ready = 4'b0000;
  endtask

  task automatic test_interrupt();
    slv_int = 4'b0110;
    #1;
    n_tests++; if (peripheral_int_code !== 4'd0) begin n_fail++; $display("FAIL int_registered: got %0d want 0", peripheral_int_code); end
    tick();
    n_tests++; if (peripheral_int_code !== 4'd2) begin n_fail++; $display("FAIL int_0110: got %0d want 2", peripheral_int_code); end
    slv_int = 4'b1000;
    tick();
    n_tests++; if (peripheral_int_code !== 4'd4) begin n_fail++; $display("FAIL int_1000: got %0d want 4", peripheral_int_code); end
    slv_int = 4'b0000;
    tick();
    n_tests++; if (peripheral_int_code !== 4'd0) begin n_fail++; $display("FAIL int_none: got %0d want 0", peripheral_int_code); end
  endtask

  task automatic test_timeout();
    slv_rdata[127:96] = 32'hFFFF_FFFF;
    slv_ready = 4'b0000;
    bus.io_addr = 32'h3000_0000; bus.io_read = 1'b1;
    tick();
`ifdef PBUS_TIMEOUT_EN
    for (int k = 2; k <= 16; k++) tick();
    n_tests++; if ({slv_read, bus.io_ready} !== 5'b1000_0) begin n_fail++; $display("FAIL tmo_last_access: got %b/%b want 1000/0", slv_read, bus.io_ready); end
    tick();
    n_tests++; if (slv_read !== 4'b0000) begin n_fail++; $display("FAIL tmo_strobe_drop: got %b want 0000", slv_read); end
    n_tests++; if ({bus.io_ready, bus.io_err} !== 2'b11) begin n_fail++; $display("FAIL tmo_resp: got rdy %b err %b want 1 1", bus.io_ready, bus.io_err); end
    n_tests++; if (bus.io_rdata !== 32'h0) begin n_fail++; $display("FAIL tmo_rdata: got %h want 0", bus.io_rdata); end
    bus.io_read = 1'b0;
    tick(); tick();
`else
    for (int k = 0; k < 24; k++) tick();
    n_tests++; if ({slv_read, bus.io_ready} !== 5'b1000_0) begin n_fail++; $display("FAIL wait_forever: got %b/%b want 1000/0", slv_read, bus.io_ready); end
    slv_ready = 4'b1000;
    tick();
    n_tests++; if ({bus.io_ready, bus.io_err} !== 2'b10) begin n_fail++; $display("FAIL wait_resp: got rdy %b err %b want 1 0", bus.io_ready, bus.io_err); end
    n_tests++; if (bus.io_rdata !== 32'hFFFF_FFFF) begin n_fail++; $display("FAIL wait_data: got %h want ffffffff", bus.io_rdata); end
    bus.read_ready = 1'b1; bus.io_read = 1'b0;
    tick(); tick();
    bus.read_ready = 1'b0; slv_ready = 4'b0000;
`endif
  endtask

  task automatic test_reset_mid_access();
    int seen_ready;
    slv_ready = 4'b0000;
    bus.io_addr = 32'h3000_0000; bus.io_read = 1'b1;
    tick();
    n_tests++; if (slv_read !== 4'b1000) begin n_fail++; $display("FAIL rma_strobe: got %b want 1000", slv_read); end
    rst_n = 1'b0;
    #1;
    n_tests++; if ({slv_read, slv_write} !== 8'h00) begin n_fail++; $display("FAIL rma_async_drop: got %b/%b want 0/0", slv_read, slv_write); end
    bus.io_read = 1'b0;
    tick(); tick();
    rst_n = 1'b1;
    seen_ready = 0;
    for (int k = 0; k < 4; k++) begin
      tick();
      if (bus.io_ready !== 1'b0 || slv_read !== 4'b0000) seen_ready++;
    end
    n_tests++; if (seen_ready != 0) begin n_fail++; $display("FAIL rma_no_resp: got %0d active cycles want 0", seen_ready); end
    slv_rdata[63:32] = 32'h0BAD_F00D; slv_ready = 4'b0010;
    bus.io_addr = 32'h1000_0004; bus.io_read = 1'b1;
    tick();
    n_tests++; if (slv_read !== 4'b0010) begin n_fail++; $display("FAIL rma_idle_accept: got %b want 0010", slv_read); end
    tick();
    n_tests++; if (bus.io_rdata !== 32'h0BAD_F00D) begin n_fail++; $display("FAIL rma_after_data: got %h want 0badf00d", bus.io_rdata); end
    bus.read_ready = 1'b1; bus.io_read = 1'b0;
    tick(); tick();
    bus.read_ready = 1'b0; slv_ready = 4'b0000;
  endtask

  initial begin
    rst_n = 1'b0;
    bus.io_addr = '0; bus.io_wdata = '0; bus.io_byte_size = BSIZE_WORD;
    bus.io_read = 1'b0; bus.io_write = 1'b0; bus.read_ready = 1'b0;
    slv_rdata = '0; slv_ready = '0; slv_int = '0;
    test_reset();
    test_read_hit();
    test_unselected_ready();
    test_both_high();
    test_write_miss();
    test_write_hit();
    test_overlap();
    test_interrupt();
    test_timeout();
    test_reset_mid_access();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/periph_bus_fabric.md
PERIPH_BUS_FABRIC -- requirements
Module: periph_bus_fabric

Interface
REQ-001 SHALL have parameter XLEN, default 32, data/address width.
REQ-002 SHALL have parameter NUM_SLAVES, default 4, number of slave channels (1..15).
REQ-003 SHALL have parameter INT_CODE_WIDTH, default 4, interrupt code width.
REQ-004 SHALL have parameter TIMEOUT_CYCLES, default 16, maximum ACCESS cycles.
REQ-005 SHALL have parameters SLV_BASE and SLV_END, each NUM_SLAVES*XLEN, with inclusive window per slave (slice i = slave i).
REQ-006 SHALL have port pclk, in, 1, single clock; all logic on rising edge.
REQ-007 SHALL have port rst_n, in, 1, asynchronous active-low reset.
REQ-008 SHALL have ports io_addr/io_wdata in XLEN, io_read/io_write/read_ready in 1, io_byte_size in 2: master request.
REQ-009 SHALL have ports io_rdata out XLEN, io_ready out 1, io_err out 1: master response.
REQ-010 SHALL have ports slv_addr/slv_wdata out XLEN, slv_byte_size out 2, slv_read/slv_write out NUM_SLAVES: slave strobes.
REQ-011 SHALL have ports slv_rdata in NUM_SLAVES*XLEN, slv_ready in NUM_SLAVES, slv_int in NUM_SLAVES: slave responses and interrupts.
REQ-012 SHALL have port peripheral_int_code, out, INT_CODE_WIDTH, encoded pending interrupt.

Function
REQ-013 SHALL use FSM states IDLE, ACCESS, RESP, RELEASE.
REQ-014 In IDLE, on io_read xor io_write high, SHALL latch addr, wdata, byte_size, op and decode.
REQ-015 Decode SHALL select lowest index i with SLV_BASE[i] <= addr <= SLV_END[i]; overlapping windows resolve to lowest index.
REQ-016 On hit SHALL go to ACCESS; on miss go to RESP with io_err=1, io_rdata=0, no slave strobe.
REQ-017 io_read and io_write both high in IDLE SHALL be treated as miss (error, no strobe).
REQ-018 In ACCESS SHALL drive slv_read[i] or slv_write[i] only for selected i, others 0; slv_addr/wdata/byte_size from latched values.
REQ-019 On slv_ready[i] in ACCESS SHALL capture slv_rdata slice i (reads) into io_rdata and go to RESP with io_err=0.
REQ-020 In RESP io_ready SHALL be 1; writes and errors leave after one cycle; reads hold RESP until read_ready=1.
REQ-021 RELEASE SHALL hold until io_read=0 and io_write=0, then go to IDLE; prevents re-issue of the same request.
REQ-022 Latency: slave ready in first ACCESS cycle SHALL yield io_ready two cycles after IDLE sampling of the request.
REQ-023 io_rdata SHALL hold last captured value outside RESP; slv_ready of unselected slaves SHALL be ignored.
REQ-024 peripheral_int_code SHALL be registered (1-cycle latency): index+1 of lowest asserted slv_int, 0 if none.

Reset
REQ-025 rst_n low SHALL force IDLE, all strobes 0, io_ready=0, io_err=0, io_rdata=0, peripheral_int_code=0, timeout counter 0.
REQ-026 Reset mid-ACCESS SHALL drop strobes immediately (asynchronously) with no response issued.

Configuration
REQ-027 Macro PBUS_TIMEOUT_EN defined: ACCESS cycles counted; at TIMEOUT_CYCLES without slv_ready SHALL drop strobes, go to RESP with io_err=1, io_rdata=0.
REQ-028 Macro PBUS_TIMEOUT_EN undefined: no counter; ACCESS SHALL wait indefinitely for slv_ready.

Structure
REQ-029 Package periph_bus_pkg SHALL hold FSM state encoding, default window constants and byte-size codes.
REQ-030 Address decode SHALL be sub-module periph_addr_decode (combinational hit vector, index, miss flag).

Verification
REQ-031 Read at 0x1000_0004 hitting slave 1 ready immediately, rdata 0xDEADBEEF -> io_ready cycle+2, io_rdata 0xDEADBEEF, io_err 0.
REQ-032 Write to unmapped 0xFFFF_0000 -> no slv_write bit, io_ready one cycle, io_err 1, io_rdata 0.
REQ-033 With PBUS_TIMEOUT_EN, TIMEOUT_CYCLES=16, slave never ready -> strobe drops after 16 cycles, io_err 1.
REQ-034 slv_int=4'b0110 -> peripheral_int_code 2 next cycle; slv_int=0 -> 0.
REQ-035 Overlapping windows slaves 0 and 2, read in overlap -> only slv_read[0] asserted.
REQ-036 rst_n low during ACCESS -> strobes 0 immediately, FSM IDLE, no io_ready after release.
